// File: rtl/ps2_move_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_move_decoder
// Description : PS/2 keyboard receiver and set-2 scan-code decoder. Turns
//               make/break codes for the arrow keys (and optionally W/S/A/D)
//               into level-held movement controls. Receive only; the PS/2
//               lines are never driven.
// Ports       : clk         - system clock
//               reset       - asynchronous, active-low reset
//               ps2_clk     - raw PS/2 clock (asynchronous)
//               ps2_data    - raw PS/2 data (asynchronous)
//               move_up/down/left/right - high while the mapped key is held
//               scan_code   - last good received byte
//               scan_valid  - one-cycle pulse, scan_code updated
//               frame_err   - one-cycle pulse, frame rejected
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_move_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int ENABLE_WASD    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] c_CODE_EXT = 8'hE0;
    localparam logic [7:0] c_CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_EXT    = 2'd1,
        D_BRK    = 2'd2,
        D_EXTBRK = 2'd3
    } dec_state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and ps2_clk glitch filter
    // ------------------------------------------------------------------
    logic           r_clk_s1, r_clk_s2;
    logic           r_dat_s1, r_dat_s2;
    logic           r_clk_filt, r_clk_filt_d;
    logic [FCW-1:0] r_filt_cnt;
    logic           w_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= ps2_data;
            r_dat_s2     <= r_dat_s1;
            r_clk_filt_d <= r_clk_filt;
            // Count consecutive samples that disagree with the filtered level;
            // any agreeing sample restarts the run, so short glitches vanish.
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FCW'(1);
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    rx_state_t      r_rx_state;
    logic [3:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic           r_stop;
    logic [TCW-1:0] r_timer;
    logic [7:0]     r_scan_code;
    logic           r_scan_valid;
    logic           r_frame_err;
    logic           w_accept;
    logic           w_reject;
    logic           w_timeout;

    // Odd parity over data+parity is what a good frame carries.
    assign w_accept  = (r_rx_state == RX_CHECK) && r_stop && (^{r_shift, r_parity});
    assign w_reject  = (r_rx_state == RX_CHECK) && !w_accept;
    assign w_timeout = (r_rx_state == RX_SHIFT) && !w_fall &&
                       (r_timer == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= RX_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_stop       <= 1'b0;
            r_timer      <= '0;
            r_scan_code  <= 8'h00;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_timer <= '0;
                    // A high start bit is treated as noise and ignored.
                    if (w_fall && !r_dat_s2) begin
                        r_rx_state <= RX_SHIFT;
                        r_bit_cnt  <= 4'd0;
                    end
                end
                RX_SHIFT: begin
                    if (w_fall) begin
                        r_timer   <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt < 4'd8) begin
                            r_shift <= {r_dat_s2, r_shift[7:1]};
                        end else if (r_bit_cnt == 4'd8) begin
                            r_parity <= r_dat_s2;
                        end else begin
                            r_stop     <= r_dat_s2;
                            r_rx_state <= RX_CHECK;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_rx_state  <= RX_IDLE;
                        r_timer     <= '0;
                        r_shift     <= 8'h00;
                    end else begin
                        r_timer <= r_timer + TCW'(1);
                    end
                end
                RX_CHECK: begin
                    if (w_accept) begin
                        r_scan_code  <= r_shift;
                        r_scan_valid <= 1'b1;
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                    r_timer    <= '0;
                    r_rx_state <= RX_IDLE;
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder
    // ------------------------------------------------------------------
    // Direction mask bit order: [0] up, [1] down, [2] left, [3] right.
    function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
        logic [3:0] m;
        m = 4'b0000;
        if (ext) begin
            case (code)
                8'h75:   m = 4'b0001;
                8'h72:   m = 4'b0010;
                8'h6B:   m = 4'b0100;
                8'h74:   m = 4'b1000;
                default: m = 4'b0000;
            endcase
        end else if (ENABLE_WASD != 0) begin
            case (code)
                8'h1D:   m = 4'b0001;
                8'h1B:   m = 4'b0010;
                8'h1C:   m = 4'b0100;
                8'h23:   m = 4'b1000;
                default: m = 4'b0000;
            endcase
        end
        return m;
    endfunction

    dec_state_t r_dec_state;
    logic [3:0] r_moves;

    // Decoder steps on the same edge that publishes the byte, so move_*
    // changes together with scan_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dec_state <= D_IDLE;
            r_moves     <= 4'b0000;
        end else if (w_reject || w_timeout) begin
            // A lost byte may have been a prefix; resynchronise, keep levels.
            r_dec_state <= D_IDLE;
        end else if (w_accept) begin
            case (r_dec_state)
                D_IDLE: begin
                    if (r_shift == c_CODE_EXT) begin
                        r_dec_state <= D_EXT;
                    end else if (r_shift == c_CODE_BRK) begin
                        r_dec_state <= D_BRK;
                    end else begin
                        r_moves <= r_moves | key_mask(r_shift, 1'b0);
                    end
                end
                D_EXT: begin
                    if (r_shift == c_CODE_BRK) begin
                        r_dec_state <= D_EXTBRK;
                    end else if (r_shift != c_CODE_EXT) begin
                        r_moves     <= r_moves | key_mask(r_shift, 1'b1);
                        r_dec_state <= D_IDLE;
                    end
                end
                D_BRK: begin
                    r_moves     <= r_moves & ~key_mask(r_shift, 1'b0);
                    r_dec_state <= D_IDLE;
                end
                D_EXTBRK: begin
                    r_moves     <= r_moves & ~key_mask(r_shift, 1'b1);
                    r_dec_state <= D_IDLE;
                end
                default: begin
                    r_dec_state <= D_IDLE;
                end
            endcase
        end
    end

    assign move_up    = r_moves[0];
    assign move_down  = r_moves[1];
    assign move_left  = r_moves[2];
    assign move_right = r_moves[3];
    assign scan_code  = r_scan_code;
    assign scan_valid = r_scan_valid;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_move_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_move_decoder
// Description : Directed self-checking bench for ps2_move_decoder. Drives
//               PS/2 frames (1 us bit period) and checks decoded outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_move_decoder;

    localparam int TB_TIMEOUT = 300;  // 3 us at 100 MHz, three bit periods

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       move_up, move_down, move_left, move_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    ps2_move_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .ENABLE_WASD    (1)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (scan_valid) valid_cnt++;
        if (frame_err)  err_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One PS/2 frame: data changes mid-high, falling edge mid-bit.
    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            if (glitch) begin
                #100; ps2_clk = 1'b0; #30; ps2_clk = 1'b1; #120;
            end else begin
                #250;
            end
            ps2_clk = 1'b0;
            #500;
            ps2_clk = 1'b1;
            #250;
        end
        ps2_data = 1'b1;
        #2000;
    endtask

    task automatic test_reset();
        checks++;
        if ({move_up, move_down, move_left, move_right, scan_code, scan_valid, frame_err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {move_up, move_down, move_left, move_right, scan_code, scan_valid, frame_err});
        end
    endtask

    task automatic test_ext_make();
        int v0;
        v0 = valid_cnt;
        send_byte(8'hE0, 1'b0, 1'b0);
        checks++;
        if (move_up !== 1'b0) begin errors++; $display("FAIL prefix_no_move got %b exp 0", move_up); end
        send_byte(8'h75, 1'b0, 1'b0);
        checks++;
        if (move_up !== 1'b1) begin errors++; $display("FAIL up_make got %b exp 1", move_up); end
        checks++;
        if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL up_make_valid got %0d exp 2", valid_cnt - v0); end
        checks++;
        if (scan_code !== 8'h75) begin errors++; $display("FAIL up_make_code got %h exp 75", scan_code); end
    endtask

    task automatic test_ext_break();
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        checks++;
        if ({move_up, move_down, move_left, move_right} !== 4'b0000) begin
            errors++; $display("FAIL up_break got %b exp 0000", {move_up, move_down, move_left, move_right});
        end
    endtask

    task automatic test_bad_parity();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h6B, 1'b1, 1'b0);
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL parity_err_pulses got %0d exp 1", err_cnt - e0); end
        checks++;
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL parity_no_valid got %0d exp 0", valid_cnt - v0); end
        checks++;
        if (move_left !== 1'b0) begin errors++; $display("FAIL parity_left_kept got %b exp 0", move_left); end
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h6B, 1'b0, 1'b0);
        checks++;
        if (move_left !== 1'b1) begin errors++; $display("FAIL left_make got %b exp 1", move_left); end
    endtask

    task automatic test_timeout();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        // Start bit plus five data bits of 8'h1D, then the keyboard goes quiet.
        for (int i = 0; i < 6; i++) begin
            ps2_data = (i == 0) ? 1'b0 : ((8'h1D >> (i - 1)) & 1);
            #250; ps2_clk = 1'b0; #500; ps2_clk = 1'b1; #250;
        end
        ps2_data = 1'b1;
        #6000;
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err got %0d exp 1", err_cnt - e0); end
        checks++;
        if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL timeout_no_valid got %0d exp 0", valid_cnt - v0); end
        send_byte(8'h1D, 1'b0, 1'b0);
        checks++;
        if (move_up !== 1'b1) begin errors++; $display("FAIL wasd_up got %b exp 1", move_up); end
        checks++;
        if (scan_code !== 8'h1D) begin errors++; $display("FAIL wasd_code got %h exp 1d", scan_code); end
    endtask

    task automatic test_multi_key_and_reset();
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h74, 1'b0, 1'b0);
        // Typematic repeat of right.
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h74, 1'b0, 1'b0);
        checks++;
        if ({move_up, move_down, move_left, move_right} !== 4'b1011) begin
            errors++; $display("FAIL multi_hold got %b exp 1011", {move_up, move_down, move_left, move_right});
        end
        // Partial frame, then reset while the clock is low.
        for (int i = 0; i < 4; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            #250; ps2_clk = 1'b0; #500; ps2_clk = 1'b1; #250;
        end
        ps2_data = 1'b0;
        #250; ps2_clk = 1'b0; #200;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({move_up, move_down, move_left, move_right, scan_code, scan_valid, frame_err} !== 14'h0) begin
            errors++; $display("FAIL async_reset got %b exp 0", {move_up, move_down, move_left, move_right, scan_code, scan_valid, frame_err});
        end
    endtask

    task automatic test_after_reset_quiet();
        int v0, e0;
        #100;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        #100;
        v0 = valid_cnt; e0 = err_cnt;
        rst_n = 1'b1;
        #6000;
        checks++;
        if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
            errors++; $display("FAIL reset_no_pulse got %0d exp 0", (valid_cnt - v0) + (err_cnt - e0));
        end
    endtask

    task automatic test_glitch_filter();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1'b0, 1'b1);
        checks++;
        if (scan_code !== 8'h1C) begin errors++; $display("FAIL glitch_code got %h exp 1c", scan_code); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_no_err got %0d exp 0", err_cnt - e0); end
        checks++;
        if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL glitch_valid got %0d exp 1", valid_cnt - v0); end
        checks++;
        if ({move_up, move_down, move_left, move_right} !== 4'b0010) begin
            errors++; $display("FAIL glitch_left got %b exp 0010", {move_up, move_down, move_left, move_right});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #103;
        test_reset();
        rst_n = 1'b1;
        #200;
        test_ext_make();
        test_ext_break();
        test_bad_parity();
        test_timeout();
        test_multi_key_and_reset();
        test_after_reset_quiet();
        test_glitch_filter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
